// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, FETCH, DONE, TRAP)
//   WORD_BYTES    : bytes per instruction word, the PC step
//   NOP_INSTR     : value held in the IF/ID instruction register after reset
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    TRAP  = 2'd3
  } fetch_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter register with its next-value mux.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous reset, active-low; loads RESET_PC
//   redirect_en take redirect_pc (highest priority after reset)
//   redirect_pc redirect byte address, already aligned/validated by the caller
//   advance_en  step to pc_q + WORD_BYTES (wraps modulo 2^ADDR_W)
//   pc_q        current program counter
module pc_register
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance_en,
  output logic [ADDR_W-1:0] pc_q
);

  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    pc_next = pc_q;
    if (redirect_en) begin
      pc_next = redirect_pc;
    end else if (advance_en) begin
      pc_next = pc_q + ADDR_W'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into an IF/ID stage with a valid/ready
// handshake toward decode. Handles redirects, stalls and a stop at PC_LIMIT.
// Optional build macro: FETCH_MISALIGN_TRAP_EN adds trap_o and the TRAP state
// (a misaligned redirect target freezes fetch instead of being rounded down).
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous reset, active-low
//   pc_addr_o   byte address to instruction memory (current PC)
//   instr_i     memory word for pc_addr_o, same cycle
//   redirect_i  taken branch/jump; target_i is the new byte address
//   ready_i     decode accepts instr_o this cycle
//   valid_o     instr_o/pc_o hold a live instruction
//   instr_o     registered instruction
//   pc_o        byte address of instr_o
//   pc_plus4_o  pc_o + 4
//   trap_o      misaligned redirect trap (only with FETCH_MISALIGN_TRAP_EN)
//   done_o      fetch stopped at PC_LIMIT
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(128)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] pc_addr_o,
  input  logic [31:0]       instr_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic              trap_o,
`endif
  output logic              done_o
);

  fetch_state_t      state_reg, state_next;
  logic              valid_reg, valid_next;
  logic [31:0]       instr_reg, instr_next;
  logic [ADDR_W-1:0] pc_o_reg, pc_o_next;
  logic              done_reg, done_next;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              trap_reg, trap_next;
`endif

  logic              pc_redirect, pc_advance;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] pc_q;
  logic              load;
  logic              target_misaligned;

  // IF/ID register may take a new word when empty or being drained this cycle.
  assign load = !valid_reg || ready_i;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_misaligned = |target_i[1:0];
`else
  assign target_misaligned = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    valid_next  = valid_reg;
    instr_next  = instr_reg;
    pc_o_next   = pc_o_reg;
    done_next   = done_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_next   = trap_reg;
`endif
    pc_redirect = 1'b0;
    pc_advance  = 1'b0;
    // Aligned target: low bits cleared so fetch stays word aligned.
    pc_target   = target_i & ~ADDR_W'(WORD_BYTES - 1);

    if (redirect_i) begin
      // Flush: any instruction accepted this cycle is still consumed by decode.
      pc_redirect = 1'b1;
      valid_next  = 1'b0;
      done_next   = 1'b0;
      if (target_misaligned) begin
        pc_target  = target_i;
        state_next = TRAP;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_next  = 1'b1;
`endif
      end else begin
        state_next = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_next  = 1'b0;
`endif
      end
    end else begin
      unique case (state_reg)
        IDLE: state_next = FETCH;
        FETCH: begin
          if (load) begin
            if (pc_q < PC_LIMIT) begin
              instr_next = instr_i;
              pc_o_next  = pc_q;
              valid_next = 1'b1;
              pc_advance = 1'b1;
            end else begin
              valid_next = 1'b0;
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
        default: ; // DONE and TRAP hold until redirect or reset
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      instr_reg <= NOP_INSTR;
      pc_o_reg  <= '0;
      done_reg  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      instr_reg <= instr_next;
      pc_o_reg  <= pc_o_next;
      done_reg  <= done_next;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_reg  <= trap_next;
`endif
    end
  end

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .redirect_en (pc_redirect),
    .redirect_pc (pc_target),
    .advance_en  (pc_advance),
    .pc_q        (pc_q)
  );

  assign pc_addr_o  = pc_q;
  assign valid_o    = valid_reg;
  assign instr_o    = instr_reg;
  assign pc_o       = pc_o_reg;
  assign pc_plus4_o = pc_o_reg + ADDR_W'(WORD_BYTES);
  assign done_o     = done_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap_o     = trap_reg;
`endif

endmodule
